// File: rtl/sound_mixer.sv
// Four-channel stereo sample mixer: sequential accumulate of panned channel codes,
// master-volume scaling, and first-order sigma-delta bitstreams for each side.
module sound_mixer (
  input  logic       clk,
  input  logic       rst,
  input  logic       sampleStrobe,
  input  logic [3:0] ch1,
  input  logic [3:0] ch2,
  input  logic [3:0] ch3,
  input  logic [3:0] ch4,
  input  logic [7:0] nr50,
  input  logic [7:0] nr51,
  input  logic       soundOn,
  output logic [8:0] left,
  output logic [8:0] right,
  output logic       sampleValid,
  output logic       busy,
  output logic       pdmL,
  output logic       pdmR
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, ACC2, ACC3, SCALE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0][3:0] r_ch;
  logic [2:0]      r_volL;
  logic [2:0]      r_volR;
  logic [7:0]      r_pan;
  logic [5:0]      r_sumL;
  logic [5:0]      r_sumR;
  logic [8:0]      r_accL;
  logic [8:0]      r_accR;
  logic [1:0]      w_k;
  logic [3:0]      w_ch;
  logic            w_panL;
  logic            w_panR;
  logic [8:0]      w_mulL;
  logic [8:0]      w_mulR;
  logic [9:0]      w_sdL;
  logic [9:0]      w_sdR;
  logic            w_unused;

  assign w_unused = nr50[7] ^ nr50[3];
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!soundOn) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (sampleStrobe) w_next = ACC0;
        ACC0:    w_next = ACC1;
        ACC1:    w_next = ACC2;
        ACC2:    w_next = ACC3;
        ACC3:    w_next = SCALE;
        SCALE:   w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Channel index follows the accumulate state; pan bit k routes right, k+4 left.
  always_comb begin
    w_k = 2'd0;
    case (r_state)
      ACC1:    w_k = 2'd1;
      ACC2:    w_k = 2'd2;
      ACC3:    w_k = 2'd3;
      default: w_k = 2'd0;
    endcase
    w_ch   = r_ch[w_k];
    w_panL = r_pan[{1'b1, w_k}];
    w_panR = r_pan[{1'b0, w_k}];
  end

  assign w_mulL = {3'b000, r_sumL} * ({6'b000000, r_volL} + 9'd1);
  assign w_mulR = {3'b000, r_sumR} * ({6'b000000, r_volR} + 9'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch        <= '0;
      r_volL      <= '0;
      r_volR      <= '0;
      r_pan       <= '0;
      r_sumL      <= '0;
      r_sumR      <= '0;
      left        <= '0;
      right       <= '0;
      sampleValid <= 1'b0;
    end else if (!soundOn) begin
      r_sumL      <= '0;
      r_sumR      <= '0;
      left        <= '0;
      right       <= '0;
      sampleValid <= 1'b0;
    end else begin
      sampleValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sampleStrobe) begin
            r_ch   <= {ch4, ch3, ch2, ch1};
            r_volL <= nr50[6:4];
            r_volR <= nr50[2:0];
            r_pan  <= nr51;
            r_sumL <= '0;
            r_sumR <= '0;
          end
        end
        ACC0, ACC1, ACC2, ACC3: begin
          if (w_panL) r_sumL <= r_sumL + {2'b00, w_ch};
          if (w_panR) r_sumR <= r_sumR + {2'b00, w_ch};
        end
        SCALE: begin
          left        <= w_mulL;
          right       <= w_mulR;
          sampleValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_sdL = {1'b0, r_accL} + {1'b0, left};
  assign w_sdR = {1'b0, r_accR} + {1'b0, right};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accL <= '0;
      r_accR <= '0;
      pdmL   <= 1'b0;
      pdmR   <= 1'b0;
    end else if (!soundOn) begin
      r_accL <= '0;
      r_accR <= '0;
      pdmL   <= 1'b0;
      pdmR   <= 1'b0;
    end else begin
      r_accL <= w_sdL[8:0];
      r_accR <= w_sdR[8:0];
      pdmL   <= w_sdL[9];
      pdmR   <= w_sdR[9];
    end
  end

endmodule

// File: doc/sound_mixer.md
SOUND_MIXER -- requirements
Module: sound_mixer

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have port: clk  input  1  single system clock; all state changes on posedge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: sampleStrobe  input  1  one-cycle request to mix one sample.
REQ-005 SHALL have ports: ch1, ch2, ch3, ch4  input  4 each  channel DAC codes (noise channel output is ch4).
REQ-006 SHALL have port: nr50  input  8  master volume; [6:4] left vol L, [2:0] right vol R; bits 7 and 3 are ignored.
REQ-007 SHALL have port: nr51  input  8  panning; bit 4+k-1 routes chk left, bit k-1 routes chk right.
REQ-008 SHALL have port: soundOn  input  1  NR52 bit 7 master enable.
REQ-009 SHALL have ports: left, right  output  9 each  registered mixed samples.
REQ-010 SHALL have port: sampleValid  output  1  one-cycle pulse when left/right update.
REQ-011 SHALL have port: busy  output  1  high while a mix is in progress.
REQ-012 SHALL have ports: pdmL, pdmR  output  1 each  first-order sigma-delta bitstreams.

Function
REQ-013 FSM states SHALL be IDLE, ACC0..ACC3, SCALE; busy = (state != IDLE).
REQ-014 In IDLE with soundOn=1, sampleStrobe=1 at edge E0 SHALL snapshot ch1..ch4, nr50 and nr51, clear sumL and sumR (6 bits each), and enter ACC0.
REQ-015 ACCk (k=0..3) at edge E(k+1) SHALL add snapshot ch(k+1) to sumL if its left bit is set and to sumR if its right bit is set, then advance; ACC3 goes to SCALE.
REQ-016 SCALE at E5 SHALL load left = sumL*(L+1) and right = sumR*(R+1), unsigned, maximum 60*8 = 480 with no overflow, pulse sampleValid for exactly the following cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed: strobe sampled at E0, outputs and sampleValid visible after E5; a new strobe is accepted at E6 at the earliest.
REQ-018 sampleStrobe while busy SHALL be ignored, with no queueing and no effect on the current mix.
REQ-019 Input changes after E0 SHALL NOT affect the sample in progress.
REQ-020 left and right SHALL hold their value between updates.
REQ-021 soundOn=0 SHALL, at the next edge, force state IDLE, clear sums, left, right, both sigma-delta accumulators and sampleValid, and ignore strobes; this overrides any mix in progress, including one in SCALE.
REQ-022 Each sigma-delta channel SHALL have a 9-bit accumulator updated every clock as {carry, acc} = acc + sample (10-bit sum), with pdm = registered carry; output density = sample/512.
REQ-023 sample SHALL be the registered left (or right) value, so a new sample takes effect on the sigma-delta channel the cycle after sampleValid.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, set state IDLE, sums 0, left=right=0, sampleValid=0, busy=0, both accumulators 0, pdmL=pdmR=0.
REQ-025 Deassertion of rst mid-operation SHALL leave the block in IDLE; no partial sample SHALL ever be output.

Verification
REQ-026 ch1..ch4=15, nr51=0xFF, nr50=0x77, strobe -> busy for 5 cycles, left=right=480 with sampleValid after E5.
REQ-027 ch1=3, ch4=10, others 0, nr51=0x81, nr50=0x20 -> left=30, right=3.
REQ-028 Strobe at E0, change ch1 and assert a second strobe at E2 -> result uses E0 values only, exactly one sampleValid pulse.
REQ-029 Assert rst at E3 of a mix -> outputs 0 immediately, no sampleValid, IDLE after release; soundOn dropped at E4 -> same cleared result at next edge.
REQ-030 left=256 held for 512 cycles -> pdmL high exactly 256 cycles, alternating 0/1; left=0 -> pdmL constant 0.
REQ-031 nr50=0x88, channels active -> bits 7 and 3 ignored, scale factor 1 both sides.
